mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter.sv | 95 +++++++++
 tb/tb_mem_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Request/response types and the bundle of buses between the two requesters,
// the arbiter and the shared memory port.
package mem_arbiter_pkg;
  typedef struct packed {
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_t;

  typedef struct packed {
    logic [31:0] mem_rdata;
    logic        mem_ready;
  } mem_out_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } fsm_t;
endpackage

interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  // Handshake: a requester raises mem_valid with its fields and holds them
  // stable until it sees mem_ready=1; a new request may follow the next cycle.
  mem_in_t  imem_in;
  mem_out_t imem_out;
  mem_in_t  dmem_in;
  mem_out_t dmem_out;
  mem_in_t  mem_in;
  mem_out_t mem_out;

  // Arbiter side.
  modport slave (
    input  imem_in, dmem_in, mem_out,
    output imem_out, dmem_out, mem_in
  );

  // Requesters and memory side.
  modport master (
    output imem_in, dmem_in, mem_out,
    input  imem_out, dmem_out, mem_in
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for a single shared memory port, with a
// bounded number of consecutive beats per owner while the other side waits.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int hold_max = 8
) (
  input  logic        clk,
  input  logic        rst,
  mem_arbiter_if.slave bus,
  output fsm_t        fsm_state,
  output logic        last_owner,
  output logic [7:0]  hold_cnt
);

  localparam logic [8:0] HOLD = 9'(hold_max);

  fsm_t       fsm;
  logic       last;
  logic [7:0] cnt;

  logic       own_d;
  mem_in_t    own_req;
  logic       other_valid;
  logic [8:0] cnt_inc;

  assign own_d       = (fsm == OWN_D);
  assign own_req     = own_d ? bus.dmem_in : bus.imem_in;
  assign other_valid = own_d ? bus.imem_in.mem_valid : bus.dmem_in.mem_valid;
  assign cnt_inc     = {1'b0, cnt} + 9'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm  <= IDLE;
      last <= 1'b1;
      cnt  <= 8'd0;
    end else begin
      case (fsm)
        IDLE: begin
          cnt <= 8'd0;
          // On a tie the side that did not own last goes first.
          if (bus.imem_in.mem_valid && bus.dmem_in.mem_valid)
            fsm <= last ? OWN_I : OWN_D;
          else if (bus.imem_in.mem_valid)
            fsm <= OWN_I;
          else if (bus.dmem_in.mem_valid)
            fsm <= OWN_D;
          else
            fsm <= IDLE;
        end
        OWN_I, OWN_D: begin
          if (!own_req.mem_valid) begin
            last <= own_d;
            cnt  <= 8'd0;
            if (other_valid) fsm <= own_d ? OWN_I : OWN_D;
            else             fsm <= IDLE;
          end else if (bus.mem_out.mem_ready) begin
            if (other_valid && (cnt_inc >= HOLD)) begin
              fsm  <= own_d ? OWN_I : OWN_D;
              last <= own_d;
              cnt  <= 8'd0;
            end else begin
              cnt <= (cnt_inc > HOLD) ? HOLD[7:0] : cnt_inc[7:0];
            end
          end
        end
        default: begin
          fsm <= IDLE;
          cnt <= 8'd0;
        end
      endcase
    end
  end

  // Only the owner sees memory, and ready only while its request is live.
  always_comb begin
    bus.mem_in   = '0;
    bus.imem_out = '0;
    bus.dmem_out = '0;
    if (fsm == OWN_I) begin
      bus.mem_in             = bus.imem_in;
      bus.imem_out.mem_rdata = bus.mem_out.mem_rdata;
      bus.imem_out.mem_ready = bus.mem_out.mem_ready & bus.imem_in.mem_valid;
    end else if (fsm == OWN_D) begin
      bus.mem_in             = bus.dmem_in;
      bus.dmem_out.mem_rdata = bus.mem_out.mem_rdata;
      bus.dmem_out.mem_ready = bus.mem_out.mem_ready & bus.dmem_in.mem_valid;
    end
  end

  assign fsm_state  = fsm;
  assign last_owner = last;
  assign hold_cnt   = cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at hold_max=8 for the main
// sequence and one at hold_max=1 for strict alternation.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mem_arbiter_if bus8();
  mem_arbiter_if bus1();

  fsm_t       fsm8, fsm1;
  logic       last8, last1;
  logic [7:0] cnt8, cnt1;

  mem_arbiter #(.hold_max(8)) u_dut8 (
    .clk(clk), .rst(rst), .bus(bus8.slave),
    .fsm_state(fsm8), .last_owner(last8), .hold_cnt(cnt8)
  );

  mem_arbiter #(.hold_max(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave),
    .fsm_state(fsm1), .last_owner(last1), .hold_cnt(cnt1)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; checks follow after settling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic mem_in_t mk_req(input logic [31:0] addr,
                                     input logic [31:0] wdata,
                                     input logic [3:0] wstrb,
                                     input logic fence, input logic instr);
    mem_in_t r;
    r.mem_valid = 1'b1;
    r.mem_fence = fence;
    r.mem_instr = instr;
    r.mem_addr  = addr;
    r.mem_wdata = wdata;
    r.mem_wstrb = wstrb;
    return r;
  endfunction

  function automatic mem_out_t mk_rsp(input logic [31:0] rdata,
                                      input logic ready);
    mem_out_t r;
    r.mem_rdata = rdata;
    r.mem_ready = ready;
    return r;
  endfunction

  mem_in_t  exp_req;
  mem_out_t exp_rsp;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus8.imem_in = '0; bus8.dmem_in = '0; bus8.mem_out = '0;
    bus1.imem_in = '0; bus1.dmem_in = '0; bus1.mem_out = '0;
    step(); step();
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_fsm", fsm8, IDLE);
    check("rst_last", last8, 1'b1);
    check("rst_cnt", cnt8, 8'd0);
    check("rst_mem_in", bus8.mem_in, 71'd0);
    check("rst_imem_out", bus8.imem_out, 33'd0);
    check("rst_dmem_out", bus8.dmem_out, 33'd0);

    // Single I request: one cycle of arbitration latency, then pass-through
    bus8.imem_in = mk_req(32'h100, 32'h0, 4'h0, 1'b0, 1'b1);
    #1;
    check("i_lat_cycle1_valid", bus8.mem_in.mem_valid, 1'b0);
    step();
    check("i_lat_fsm", fsm8, OWN_I);
    exp_req = mk_req(32'h100, 32'h0, 4'h0, 1'b0, 1'b1);
    check("i_lat_cycle2_req", bus8.mem_in, exp_req);
    bus8.mem_out = mk_rsp(32'hDEAD_BEEF, 1'b1);
    #1;
    exp_rsp = mk_rsp(32'hDEAD_BEEF, 1'b1);
    check("i_rsp_pass", bus8.imem_out, exp_rsp);
    check("i_rsp_d_zero", bus8.dmem_out, 33'd0);
    step();
    check("i_cnt_after_beat", cnt8, 8'd1);
    bus8.imem_in = '0;
    bus8.mem_out = mk_rsp(32'h1234_5678, 1'b1);
    #1;
    check("i_drop_no_txn", bus8.mem_in.mem_valid, 1'b0);
    check("i_drop_no_ready", bus8.imem_out.mem_ready, 1'b0);
    step();
    check("i_drop_idle", fsm8, IDLE);
    check("i_drop_last", last8, 1'b0);

    // Tie after reset: I first, D after I drops
    bus8.mem_out = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus8.imem_in = mk_req(32'h104, 32'h0, 4'h0, 1'b0, 1'b1);
    bus8.dmem_in = mk_req(32'h200, 32'hA000_0000, 4'hF, 1'b0, 1'b0);
    step();
    check("tie_grant_i", fsm8, OWN_I);
    bus8.mem_out = mk_rsp(32'h11, 1'b1);
    #1;
    check("tie_i_ready", bus8.imem_out.mem_ready, 1'b1);
    check("tie_d_zero", bus8.dmem_out, 33'd0);
    step();
    check("tie_i_stays", fsm8, OWN_I);
    bus8.imem_in = '0;
    bus8.mem_out = '0;
    step();
    check("tie_grant_d", fsm8, OWN_D);
    check("tie_last_i", last8, 1'b0);
    check("tie_cnt0", cnt8, 8'd0);

    // D 8-beat burst while I waits, then I with no bubble
    bus8.imem_in = mk_req(32'h108, 32'h0, 4'h0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      bus8.dmem_in = mk_req(32'h200 + 32'(4 * k), 32'hA000_0000 + 32'(k),
                            4'hF, 1'b0, 1'b0);
      bus8.mem_out = mk_rsp(32'h5000 + 32'(k), 1'b1);
      #1;
      check("burst_fsm", fsm8, OWN_D);
      check("burst_addr", bus8.mem_in.mem_addr, 32'h200 + 32'(4 * k));
      exp_rsp = mk_rsp(32'h5000 + 32'(k), 1'b1);
      check("burst_d_rsp", bus8.dmem_out, exp_rsp);
      check("burst_i_zero", bus8.imem_out, 33'd0);
      step();
    end
    check("burst_handoff_fsm", fsm8, OWN_I);
    check("burst_handoff_last", last8, 1'b1);
    check("burst_handoff_cnt", cnt8, 8'd0);
    check("burst_handoff_addr", bus8.mem_in.mem_addr, 32'h108);

    // Reset while D owns and memory holds ready high
    bus8.imem_in = '0;
    bus8.dmem_in = mk_req(32'h300, 32'h0, 4'h0, 1'b0, 1'b0);
    bus8.mem_out = '0;
    step();
    check("mid_rst_own_d", fsm8, OWN_D);
    bus8.mem_out = mk_rsp(32'hCAFE_F00D, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("mid_rst_idle", fsm8, IDLE);
    check("mid_rst_mem_in", bus8.mem_in, 71'd0);
    check("mid_rst_dmem_out", bus8.dmem_out, 33'd0);
    check("mid_rst_imem_out", bus8.imem_out, 33'd0);
    bus8.dmem_in = '0;
    bus8.mem_out = '0;
    step();
    check("mid_rst_stay_idle", fsm8, IDLE);

    // D fence forwarded unchanged, completion routed to D only
    exp_req = mk_req(32'h400, 32'h0, 4'h0, 1'b1, 1'b0);
    bus8.dmem_in = exp_req;
    step();
    check("fence_grant", fsm8, OWN_D);
    check("fence_fwd", bus8.mem_in, exp_req);
    bus8.mem_out = mk_rsp(32'h0, 1'b1);
    #1;
    check("fence_d_ready", bus8.dmem_out.mem_ready, 1'b1);
    check("fence_i_zero", bus8.imem_out, 33'd0);
    step();
    bus8.dmem_in = '0;
    bus8.mem_out = '0;
    step();
    check("fence_done_idle", fsm8, IDLE);
    check("fence_done_last", last8, 1'b1);

    // hold_max=1: strict per-beat alternation, no bubble
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus1.imem_in = mk_req(32'h500, 32'h0, 4'h0, 1'b0, 1'b1);
    bus1.dmem_in = mk_req(32'h600, 32'h0, 4'h0, 1'b0, 1'b0);
    bus1.mem_out = mk_rsp(32'h77, 1'b1);
    step();
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        check("alt_fsm_i", fsm1, OWN_I);
        check("alt_i_ready", bus1.imem_out.mem_ready, 1'b1);
        check("alt_d_no_ready", bus1.dmem_out.mem_ready, 1'b0);
      end else begin
        check("alt_fsm_d", fsm1, OWN_D);
        check("alt_d_ready", bus1.dmem_out.mem_ready, 1'b1);
        check("alt_i_no_ready", bus1.imem_out.mem_ready, 1'b0);
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
